// File: rtl/wt_dcache_req_queue.sv
// rtl/wt_dcache_req_queue.sv - credit-limited in-order request FIFO between the dcache and the memory adapter
module wt_dcache_req_queue #(
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned DataWidth      = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ack_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic [DataWidth-1:0] data_o,
    input  logic                 rtrn_done_i,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam logic [OccW-1:0] OccFull = OccW'(Depth);
    localparam logic [OutW-1:0] OutMax  = OutW'(MaxOutstanding);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]      occ_q, occ_d;
    logic [OutW-1:0]      out_q, out_d;
    logic                 err_q, err_d;

    logic push, pop, rtrn_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        out_d    = out_q;

        full_o  = (occ_q == OccFull);
        empty_o = (occ_q == '0) && (out_q == '0);
        req_o   = (occ_q != '0) && (out_q < OutMax);
        push    = req_i && !full_o;
        pop     = ack_i && req_o;
        rtrn_ok = rtrn_done_i && (out_q != '0);
        ack_o   = push;
        data_o  = mem_q[rd_ptr_q];

        // Depth is a power of two, so the pointers wrap by plain overflow.
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase

        case ({pop, rtrn_ok})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase

        err_d = err_q || (ack_i && !req_o) || (rtrn_done_i && (out_q == '0));
        err_o = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && (occ_q == '0)));
    a_out_bound:    assert property (@(posedge clk_i) disable iff (rst_i) (out_q <= OutMax));

endmodule

// File: tb/tb_wt_dcache_req_queue.sv
// tb/tb_wt_dcache_req_queue.sv - vector table, directed credit sequence and random scoreboard run
module tb_wt_dcache_req_queue;

    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int MAXOUT = 8;

    logic          clk = 1'b0;
    logic          rst, req_i, ack_i, rtrn;
    logic [DW-1:0] data_i;
    logic          ack_o, req_o, empty_o, full_o, err_o;
    logic [DW-1:0] data_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_q[$];
    int            m_out;
    bit            m_err;
    bit            m_valid;

    wt_dcache_req_queue #(.Depth(DEPTH), .MaxOutstanding(MAXOUT), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .ack_o(ack_o), .data_i(data_i),
        .req_o(req_o), .ack_i(ack_i), .data_o(data_o), .rtrn_done_i(rtrn),
        .empty_o(empty_o), .full_o(full_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, req, ack, rtrn;
        logic [15:0] data;
        bit          e_ack, e_req, e_full, e_empty, e_err;
        bit          chk_data;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, compare against the model, clock, advance the model.
    task automatic cycle(input bit r, input bit rq, input logic [DW-1:0] d, input bit a, input bit rt);
        bit e_ack, e_req, e_full, e_empty;
        rst = r; req_i = rq; data_i = d; ack_i = a; rtrn = rt;
        #1;
        e_full  = (m_q.size() == DEPTH);
        e_ack   = rq && !e_full;
        e_req   = (m_q.size() != 0) && (m_out < MAXOUT);
        e_empty = (m_q.size() == 0) && (m_out == 0);
        if (m_valid) begin
            chk("ack_o", 32'(ack_o), 32'(e_ack));
            chk("req_o", 32'(req_o), 32'(e_req));
            chk("full_o", 32'(full_o), 32'(e_full));
            chk("empty_o", 32'(empty_o), 32'(e_empty));
            chk("err_o", 32'(err_o), 32'(m_err));
            if (e_req) chk("data_o", 32'(data_o), 32'(m_q[0]));
        end
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_out = 0; m_err = 0; m_valid = 1;
        end else if (m_valid) begin
            if (a && !e_req) m_err = 1;
            if (rt && m_out == 0) m_err = 1;
            if (a && e_req) begin
                void'(m_q.pop_front());
                m_out++;
            end
            if (rt && m_out > 0 && !(a && e_req && m_out == 1 && 0)) m_out--;
            if (e_ack) m_q.push_back(d);
        end
        #1;
    endtask

    function automatic vec_t mk(bit r, bit rq, logic [15:0] d, bit a, bit rt,
                                bit ea, bit er, bit ef, bit ee, bit eerr, bit cd, logic [15:0] ed);
        vec_t v;
        v.rst = r; v.req = rq; v.data = d; v.ack = a; v.rtrn = rt;
        v.e_ack = ea; v.e_req = er; v.e_full = ef; v.e_empty = ee; v.e_err = eerr;
        v.chk_data = cd; v.e_data = ed;
        return v;
    endfunction

    initial begin
        bit rq, a, rt;
        vec_t v;
        rst = 1; req_i = 0; ack_i = 0; rtrn = 0; data_i = '0;
        m_out = 0; m_err = 0; m_valid = 0;
        #1;
        cycle(1, 0, '0, 0, 0);

        //            rst req data    ack rtn  ack req full emp err cd  data
        tbl.push_back(mk(0, 1, 16'h00A1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 1, 16'h00B2, 0, 0, 1, 1, 0, 0, 0, 1, 16'h00A1));
        tbl.push_back(mk(0, 1, 16'h00C3, 0, 0, 1, 1, 0, 0, 0, 1, 16'h00A1));
        tbl.push_back(mk(0, 1, 16'h00D4, 0, 0, 1, 1, 0, 0, 0, 1, 16'h00A1));
        tbl.push_back(mk(0, 1, 16'h00E5, 0, 0, 0, 1, 1, 0, 0, 1, 16'h00A1));
        tbl.push_back(mk(0, 1, 16'h00E5, 1, 0, 0, 1, 1, 0, 0, 1, 16'h00A1));
        tbl.push_back(mk(0, 1, 16'h00E5, 0, 0, 1, 1, 0, 0, 0, 1, 16'h00B2));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 1, 0, 0, 1, 16'h00B2));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h00C3));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 1, 0, 0, 0, 1, 16'h00D4));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 1, 16'h00E5));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 1, 16'h00E5));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 1, 16'h00E5));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h00E5));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0));

        foreach (tbl[i]) begin
            v = tbl[i];
            rst = v.rst; req_i = v.req; data_i = v.data; ack_i = v.ack; rtrn = v.rtrn;
            #1;
            chk($sformatf("vec%0d.ack_o", i), 32'(ack_o), 32'(v.e_ack));
            chk($sformatf("vec%0d.req_o", i), 32'(req_o), 32'(v.e_req));
            chk($sformatf("vec%0d.full_o", i), 32'(full_o), 32'(v.e_full));
            chk($sformatf("vec%0d.empty_o", i), 32'(empty_o), 32'(v.e_empty));
            chk($sformatf("vec%0d.err_o", i), 32'(err_o), 32'(v.e_err));
            if (v.chk_data) chk($sformatf("vec%0d.data_o", i), 32'(data_o), 32'(v.e_data));
            @(posedge clk);
            #1;
        end

        // Credit exhaustion: keep pushing and accepting until eight are outstanding.
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            a = (m_q.size() != 0) && (m_out < MAXOUT);
            cycle(0, 1, DW'(16'h1000 + i), a, 0);
        end
        chk("credit.out_at_max", 32'(m_out), 32'(MAXOUT));
        chk("credit.req_o_blocked", 32'(req_o), 32'(0));
        cycle(0, 0, '0, 0, 1);
        chk("credit.req_o_after_rtrn", 32'(req_o), 32'(1));
        cycle(0, 0, '0, 1, 0);
        chk("credit.req_o_reblocked", 32'(req_o), 32'(0));
        for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0, 1);
        while (m_q.size() != 0 || m_out != 0) begin
            a = (m_q.size() != 0) && (m_out < MAXOUT);
            cycle(0, 0, '0, a, m_out > 0);
        end
        cycle(0, 0, '0, 0, 0);

        // Random legal traffic through the scoreboard model.
        cycle(1, 0, '0, 0, 0);
        for (int i = 0; i < 10000; i++) begin
            rq = ($urandom_range(0, 9) < 7);
            a  = (m_q.size() != 0) && (m_out < MAXOUT) && ($urandom_range(0, 9) < 6);
            rt = (m_out > 0) && ($urandom_range(0, 9) < 4);
            cycle(0, rq, DW'($urandom), a, rt);
        end
        for (int i = 0; i < 200 && (m_q.size() != 0 || m_out != 0); i++) begin
            a = (m_q.size() != 0) && (m_out < MAXOUT);
            cycle(0, 0, '0, a, m_out > 0);
        end
        cycle(0, 0, '0, 0, 0);
        chk("random.drained_empty", 32'(empty_o), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
